// File: rtl/i2c_port_target.sv
// I2C target emulating an 8-bit quasi-bidirectional port expander at a fixed address.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low or released.
module i2c_port_target #(
  parameter logic [6:0] I2C_ADDR   = 7'h20,
  parameter logic [7:0] PORT_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       wr_strobe,
  output logic       rd_strobe,
  output logic       busy,
  output logic       addressed
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StWaitStop
  } state_e;

  // Bit 0: sync stage 1, bit 1: sync stage 2, bit 2: history stage.
  logic [2:0] scl_pipe_q, sda_pipe_q;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       done_q, done_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] port_out_q, port_out_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       busy_q, busy_d;
  logic       addressed_q, addressed_d;

  logic scl_rise, scl_fall, start_ev, stop_ev, sda_smp;

  // Synchronizers idle high so reset release never looks like a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
    end else begin
      scl_pipe_q <= {scl_pipe_q[1:0], scl};
      sda_pipe_q <= {sda_pipe_q[1:0], sda};
    end
  end

  assign scl_rise = scl_pipe_q[1] & ~scl_pipe_q[2];
  assign scl_fall = ~scl_pipe_q[1] & scl_pipe_q[2];
  assign start_ev = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[2] & ~sda_pipe_q[1];
  assign stop_ev  = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[2] & sda_pipe_q[1];
  assign sda_smp  = sda_pipe_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    done_d      = done_q;
    sda_oe_d    = sda_oe_q;
    port_out_d  = port_out_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;

    if (stop_ev) begin
      state_d     = StIdle;
      sda_oe_d    = 1'b0;
      done_d      = 1'b0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else if (start_ev) begin
      state_d     = StAddr;
      cnt_d       = 3'd7;
      done_d      = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr, StWrite: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_smp};
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q == 3'd0) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == StWrite) begin
              port_out_d  = shift_q;
              wr_strobe_d = 1'b1;
              sda_oe_d    = 1'b1;
              state_d     = StWriteAck;
            end else if (shift_q[7:1] == I2C_ADDR) begin
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
              state_d     = StAddrAck;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            cnt_d  = 3'd7;
            done_d = 1'b0;
            if (shift_q[0]) begin
              shift_d     = port_in;
              rd_strobe_d = 1'b1;
              sda_oe_d    = ~port_in[7];
              state_d     = StRead;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StWrite;
            end
          end
        end
        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd7;
            state_d  = StWrite;
          end
        end
        StRead: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              done_d   = 1'b0;
              state_d  = StReadAck;
            end else begin
              cnt_d    = cnt_q - 3'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StReadAck: begin
          // ACK is sampled on the rise; the next byte is loaded on the following fall.
          if (scl_rise) begin
            if (sda_smp) state_d = StWaitStop;
            else         done_d  = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d      = 1'b0;
            cnt_d       = 3'd7;
            shift_d     = port_in;
            rd_strobe_d = 1'b1;
            sda_oe_d    = ~port_in[7];
            state_d     = StRead;
          end
        end
        StWaitStop: sda_oe_d = 1'b0;
        StIdle:     sda_oe_d = 1'b0;
        default:    state_d  = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd7;
      shift_q     <= 8'h00;
      done_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      port_out_q  <= PORT_RESET;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      sda_oe_q    <= sda_oe_d;
      port_out_q  <= port_out_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign port_out  = port_out_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_port_target.sv
// Bench for i2c_port_target: a bit-banged I2C controller plus a transaction-level
// model of the expander (ACK per address, last written byte, bytes read back).
module tb_i2c_port_target;

  localparam int Q = 10;  // quarter bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  logic [7:0] port_in = 8'h00;
  logic [7:0] port_out;
  logic       wr_strobe, rd_strobe, busy, addressed;
  wire        sda;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_port_target #(
    .I2C_ADDR  (7'h20),
    .PORT_RESET(8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .port_in  (port_in),
    .port_out (port_out),
    .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe),
    .busy     (busy),
    .addressed(addressed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, dut_low_cnt = 0, idle_drive_cnt = 0, bad_po_cnt = 0;
  logic [7:0] po_prev = 8'hFF;
  logic [7:0] m_port = 8'hFF;

  always @(negedge clk) begin
    if (wr_strobe) wr_cnt <= wr_cnt + 1;
    if (rd_strobe) rd_cnt <= rd_cnt + 1;
    if (!tb_sda_low && sda == 1'b0) dut_low_cnt <= dut_low_cnt + 1;
    if (!busy && !tb_sda_low && sda == 1'b0) idle_drive_cnt <= idle_drive_cnt + 1;
    if (port_out != po_prev && !wr_strobe && !rst) bad_po_cnt <= bad_po_cnt + 1;
    po_prev <= port_out;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    tb_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b0;        wait_clk(Q);
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    tb_sda_low = 1'b0; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    tb_sda_low = ~b; wait_clk(Q);
    scl = 1'b1;      wait_clk(2 * Q);
    scl = 1'b0;      wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    tb_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;        wait_clk(Q);
    b = sda;           wait_clk(Q);
    scl = 1'b0;        wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  // port_in takes next_pin before the controller's ACK bit, ready for the next capture.
  task automatic read_byte(input logic ack, input logic [7:0] next_pin,
                           output logic [7:0] d, output logic rel);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    port_in = next_pin;
    if (ack) begin
      write_bit(1'b0);
      rel = 1'b0;
    end else begin
      read_bit(rel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(3);
    checks++; if (port_out !== 8'hFF) begin errors++; $display("FAIL reset_port_out: got %h want ff", port_out); end
    checks++; if (busy !== 1'b0 || addressed !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b addr=%b want 0 0", busy, addressed); end
    checks++; if (wr_strobe !== 1'b0 || rd_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b want 00", wr_strobe, rd_strobe); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
    rst = 1'b0; wait_clk(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    int w0 = wr_cnt, r0 = rd_cnt, l0 = dut_low_cnt;
    logic a1, a2;
    i2c_start();
    write_byte(8'h42, a1);
    checks++; if (addressed !== 1'b0) begin errors++; $display("FAIL mis_addressed: got %b want 0", addressed); end
    write_byte(8'h5A, a2);
    i2c_stop();
    checks++; if (a1 !== 1'b0 || a2 !== 1'b0) begin errors++; $display("FAIL mis_ack: got %b%b want 00", a1, a2); end
    checks++; if (dut_low_cnt != l0) begin errors++; $display("FAIL mis_sda_low: got %0d cycles want 0", dut_low_cnt - l0); end
    checks++; if (port_out !== m_port) begin errors++; $display("FAIL mis_port_out: got %h want %h", port_out, m_port); end
    checks++; if (wr_cnt != w0 || rd_cnt != r0) begin errors++; $display("FAIL mis_strobes: got %0d/%0d want 0/0", wr_cnt - w0, rd_cnt - r0); end
  endtask

  task automatic test_write();
    int w0 = wr_cnt;
    logic a1, a2;
    i2c_start();
    write_byte(8'h40, a1);
    write_byte(8'hA5, a2);
    m_port = 8'hA5;
    checks++; if (a1 !== 1'b1 || a2 !== 1'b1) begin errors++; $display("FAIL wr_ack: got %b%b want 11", a1, a2); end
    checks++; if (port_out !== m_port) begin errors++; $display("FAIL wr_port_out: got %h want %h", port_out, m_port); end
    checks++; if (busy !== 1'b1 || addressed !== 1'b1) begin errors++; $display("FAIL wr_flags: got %b%b want 11", busy, addressed); end
    i2c_stop();
    checks++; if (busy !== 1'b0 || addressed !== 1'b0) begin errors++; $display("FAIL wr_stop_flags: got %b%b want 00", busy, addressed); end
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL wr_strobe_cnt: got %0d want 1", wr_cnt - w0); end
  endtask

  task automatic test_read();
    int r0 = rd_cnt;
    logic a;
    logic rel;
    logic [7:0] d;
    port_in = 8'h3C;
    i2c_start();
    write_byte(8'h41, a);
    read_byte(1'b0, 8'h00, d, rel);
    i2c_stop();
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got %b want 1", a); end
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rd_data: got %h want 3c", d); end
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL rd_ack_released: got %b want 1", rel); end
    checks++; if (rd_cnt - r0 != 1) begin errors++; $display("FAIL rd_strobe_cnt: got %0d want 1", rd_cnt - r0); end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, r0 = rd_cnt;
    logic [7:0] wd [3] = '{8'h11, 8'h22, 8'h33};
    logic a, acks;
    logic rel;
    logic [7:0] d0, d1;
    acks = 1'b1;
    i2c_start();
    write_byte(8'h40, a); acks &= a;
    for (int i = 0; i < 3; i++) begin
      write_byte(wd[i], a);
      acks &= a;
      m_port = wd[i];
    end
    port_in = 8'h0F;
    i2c_start();
    write_byte(8'h41, a); acks &= a;
    read_byte(1'b1, 8'hF0, d0, rel);
    read_byte(1'b0, 8'h00, d1, rel);
    i2c_stop();
    checks++; if (acks !== 1'b1) begin errors++; $display("FAIL b2b_acks: got %b want 1", acks); end
    checks++; if (port_out !== m_port) begin errors++; $display("FAIL b2b_port_out: got %h want %h", port_out, m_port); end
    checks++; if (wr_cnt - w0 != 3) begin errors++; $display("FAIL b2b_wr_cnt: got %0d want 3", wr_cnt - w0); end
    checks++; if (d0 !== 8'h0F || d1 !== 8'hF0) begin errors++; $display("FAIL b2b_rd_data: got %h %h want 0f f0", d0, d1); end
    checks++; if (rd_cnt - r0 != 2) begin errors++; $display("FAIL b2b_rd_cnt: got %0d want 2", rd_cnt - r0); end
  endtask

  task automatic test_stop_mid_byte();
    int w0 = wr_cnt;
    logic a;
    i2c_start();
    write_byte(8'h40, a);
    for (int i = 0; i < 4; i++) write_bit(1'b0);
    i2c_stop();
    checks++; if (port_out !== m_port) begin errors++; $display("FAIL mid_stop_port_out: got %h want %h", port_out, m_port); end
    checks++; if (wr_cnt != w0 || busy !== 1'b0) begin errors++; $display("FAIL mid_stop_idle: got wr=%0d busy=%b want 0 0", wr_cnt - w0, busy); end
    i2c_start();
    write_byte(8'h40, a);
    write_byte(8'h5C, a);
    i2c_stop();
    m_port = 8'h5C;
    checks++; if (port_out !== m_port || a !== 1'b1) begin errors++; $display("FAIL mid_stop_next: got %h ack=%b want %h 1", port_out, a, m_port); end
  endtask

  task automatic test_reset_mid_byte();
    logic a, b;
    port_in = 8'h00;
    i2c_start();
    write_byte(8'h41, a);
    for (int i = 0; i < 3; i++) read_bit(b);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rst_mid_held: got sda=%b want 0", sda); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_mid_release: got sda=%b want 1", sda); end
    wait_clk(2);
    m_port = 8'hFF;
    checks++; if (port_out !== 8'hFF || busy !== 1'b0 || addressed !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h %b %b want ff 0 0", port_out, busy, addressed);
    end
    rst = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(2 * Q);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_false_start: got busy=%b want 0", busy); end
    i2c_start();
    write_byte(8'h40, a);
    write_byte(8'h77, a);
    i2c_stop();
    m_port = 8'h77;
    checks++; if (port_out !== m_port) begin errors++; $display("FAIL rst_mid_next: got %h want %h", port_out, m_port); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      logic [6:0] adr;
      logic rw, ack, exp_ack, rel;
      logic [7:0] d, got, pin, nxt;
      int n, w0, r0, exp_w, exp_r;
      adr = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h20;
      rw  = 1'($urandom);
      n   = $urandom_range(1, 3);
      w0  = wr_cnt; r0 = rd_cnt; exp_w = 0; exp_r = 0;
      pin = 8'($urandom);
      port_in = pin;
      exp_ack = (adr == 7'h20);
      i2c_start();
      write_byte({adr, rw}, ack);
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rand_addr_ack: got %b want %b adr=%h", ack, exp_ack, adr); end
      if (exp_ack && !rw) begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          write_byte(d, ack);
          m_port = d;
          exp_w++;
          checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rand_wr_ack: got %b want 1", ack); end
        end
      end else if (exp_ack && rw) begin
        for (int k = 0; k < n; k++) begin
          nxt = 8'($urandom);
          read_byte(k != n - 1, nxt, got, rel);
          exp_r++;
          checks++; if (got !== pin) begin errors++; $display("FAIL rand_rd_data: got %h want %h", got, pin); end
          pin = nxt;
        end
      end
      i2c_stop();
      checks++; if (port_out !== m_port) begin errors++; $display("FAIL rand_port_out: got %h want %h", port_out, m_port); end
      checks++; if (wr_cnt - w0 != exp_w || rd_cnt - r0 != exp_r) begin
        errors++; $display("FAIL rand_strobes: got %0d/%0d want %0d/%0d", wr_cnt - w0, rd_cnt - r0, exp_w, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mismatch();
    test_write();
    test_read();
    test_back_to_back();
    test_stop_mid_byte();
    test_reset_mid_byte();
    test_random();
    checks++; if (idle_drive_cnt != 0) begin errors++; $display("FAIL idle_drive: got %0d cycles want 0", idle_drive_cnt); end
    checks++; if (bad_po_cnt != 0) begin errors++; $display("FAIL port_out_no_strobe: got %0d changes want 0", bad_po_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_port_target.md
# i2c_port_target

I2C target (slave) that emulates an 8-bit quasi-bidirectional port expander at a fixed 7-bit address. It is the bus-side counterpart of the team's `i2c_master`. It lets LCD-backpack traffic be looped back on-chip for bring-up. It also lets an FPGA expose an expander-style register to an external controller. The block oversamples SCL/SDA on the system clock, decodes START/STOP, matches the address, ACKs, latches write bytes to `port_out`, and serves `port_in` on reads.

## Interface

- `I2C_ADDR`, default 7'h20: target address.
- `PORT_RESET`, default 8'hFF: `port_out` value after reset. Expander lines power up high.
- `clk` input, 1 bit: system clock, 100 MHz nominal.
- `rst` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `scl` input, 1 bit: bus clock. The target never stretches SCL.
- `sda` inout, 1 bit: open-drain data. The block drives only 0 or z, never 1.
- `port_in` input, 8 bits: value returned on reads.
- `port_out` output, 8 bits: last byte written by the controller.
- `wr_strobe` output, 1 bit: one-cycle pulse when `port_out` updates.
- `rd_strobe` output, 1 bit: one-cycle pulse when `port_in` is captured for transmission.
- `busy` output, 1 bit: high from START until STOP.
- `addressed` output, 1 bit: high from the address ACK until STOP or repeated START.

## Operation

- **Input conditioning:** `scl` and `sda` pass through 2-FF synchronizers, then one history stage. Edges are detected between sync stage 2 and the history stage.
- **START:** SDA falls while SCL is high.
- **STOP:** SDA rises while SCL is high.
- **Sampling rule:** SDA is sampled on SCL rising edges. The target changes its SDA drive only on SCL falling edges.
- **States:**
  - IDLE → ADDR on START.
  - ADDR shifts 8 bits MSB-first.
    - Address matches and R/W=0 → ADDR_ACK, then WRITE.
    - Address matches and R/W=1 → ADDR_ACK, then READ.
    - Mismatch → WAIT_STOP, with SDA released and no ACK.
  - ADDR_ACK: pull SDA low from the SCL falling edge after bit 8 until the next SCL falling edge. `addressed` is set at ACK drive.
  - WRITE shifts 8 bits → WRITE_ACK. At the falling edge that starts the ACK: `port_out` <= byte and `wr_strobe` pulses. ACK drive follows the ADDR_ACK rule, then → WRITE for the next byte. Every byte overwrites `port_out`.
  - READ: at the falling edge ending ADDR_ACK or a controller ACK, capture `port_in` into the shift register and pulse `rd_strobe`.
    - Bit 7 is driven immediately at that edge. Bits 6..0 are driven on successive falling edges.
    - A bit value of 1 releases SDA.
    - After bit 0's falling edge, release SDA → READ_ACK.
  - READ_ACK samples the controller on the SCL rising edge.
    - 0 → reload and continue READ.
    - 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released; waits for STOP or START.
- **Global STOP/START precedence:** STOP in any state → IDLE, SDA released, `busy`/`addressed` cleared. Repeated START in any state → ADDR, bit counter cleared. These override all other transitions in the same cycle.
- **Partial bytes:** a partial write byte (STOP or START before bit 8) does not update `port_out` and does not pulse `wr_strobe`.
- **Bit counter:** 3 bits, counts 7 down to 0. Shift register is 8 bits. No other arithmetic.
- **Reset:** state IDLE, SDA released, `port_out`=`PORT_RESET`, `wr_strobe`=`rd_strobe`=`busy`=`addressed`=0. Synchronizers reset to 1 (bus idle), so reset release never fakes a START. Reset mid-transaction abandons the transfer. The block resumes only at the next START.

## Timing

- **Edge latency:** external edge to internal event detection is 3 clk cycles.
- **SDA output delay:** 3–4 clk after the external SCL falling edge. This gives 30–40 ns data hold at 100 MHz.
- **Minimum phase width:** SCL high and low phases ≥ 8 clk each. This supports bus rates ≤ 1 MHz at 100 MHz `clk`.
- **Strobes:** exactly one cycle each. `wr_strobe` coincides with the `port_out` change.
- **Bus sharing:** the block never drives SDA while the bus is idle.
- **START/STOP setup:** SDA transitions while SCL is high must be ≥ 4 clk from any SCL edge to be recognized as START/STOP.

## Test plan

- **Matched write:** START, 0x40, 0xA5, STOP at 100 kHz. → ACK after both bytes; `port_out`=0xA5; one `wr_strobe`; `busy` falls after STOP.
- **Address mismatch:** START, 0x42 (addr 0x21), 0x5A, STOP. → SDA never driven low; `port_out` stays 0xFF; no strobes; `addressed`=0.
- **Read:** `port_in`=0x3C, START, 0x41, controller reads one byte then NACKs, STOP. → SDA bits 0,0,1,1,1,1,0,0; one `rd_strobe`; SDA released in READ_ACK.
- **Multi-byte traffic:** multi-byte write 0x11, 0x22, 0x33, then repeated START, 0x41, read 2 bytes (ACK, NACK) with `port_in` changing 0x0F→0xF0 between them. → `port_out` ends 0x33 with three `wr_strobe`s; read bytes 0x0F, 0xF0; two `rd_strobe`s.
- **STOP mid-byte:** STOP after 4 data bits of a write. → `port_out` unchanged; state IDLE; the next full transaction works.
- **Reset mid-byte:** `rst` asserted mid-byte during a read while the target holds SDA low. → SDA released within 1 clk; outputs at reset values; no false START after release.
